// File: rtl/rr_mux8_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux8_pkg
// Shared constants, types and helpers for the 8:1 round-robin multiplexer.
//   N_CH   : number of source channels (8)
//   SEL_W  : width of a channel index (3)
//   sel_t  : channel index type
//   next_idx(i) : (i + 1) mod 8, the round-robin successor of a channel
// -----------------------------------------------------------------------------
package rr_mux8_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef logic [SEL_W-1:0] sel_t;

    // Natural 3-bit wrap gives the modulo-8 behaviour.
    function automatic sel_t next_idx(input sel_t i);
        return i + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_mux8_arb.sv
// -----------------------------------------------------------------------------
// rr_arb8
// Combinational round-robin arbiter over eight requesters.
// The scan starts at the channel after ptr and wraps, so ptr itself has the
// lowest priority; a lone requester sitting on ptr is therefore still granted.
// Ports:
//   req     in  [7:0]  request vector, bit k = channel k
//   ptr     in  sel_t  last granted channel
//   en      in  1      grant allowed this cycle (0 forces no grant)
//   gnt     out [7:0]  one-hot grant (all zero when nothing granted)
//   gnt_idx out sel_t  index of the granted channel (0 when none)
//   any     out 1      a grant was issued
// -----------------------------------------------------------------------------
module rr_arb8
    import rr_mux8_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  sel_t            ptr,
    input  logic            en,
    output logic [N_CH-1:0] gnt,
    output sel_t            gnt_idx,
    output logic            any
);

    sel_t scan_idx;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        any      = 1'b0;
        scan_idx = next_idx(ptr);
        // Visit ptr+1 .. ptr+8 (the last one is ptr itself); first hit wins.
        for (int i = 0; i < N_CH; i++) begin
            if (en && !any && req[scan_idx]) begin
                any     = 1'b1;
                gnt_idx = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux8.sv
// -----------------------------------------------------------------------------
// rr_mux8
// 8:1 round-robin arbitrated multiplexer with a registered output stream.
// Each output beat carries the index of its source channel on out_sel so a
// downstream 1:8 demux can route it back to the matching lane.
//
// Optional build macro: RR_MUX8_PKT_LOCK_EN
//   When defined, a grant sticks to a channel from its first beat with
//   in_last=0 until its beat with in_last=1 (packet lock). When undefined,
//   arbitration is per beat and in_last is only forwarded.
//
// Ports:
//   clk        in  1        rising-edge clock
//   rst_n      in  1        asynchronous active-low reset
//   in_valid   in  [7:0]    per-channel valid
//   in_data    in  [8*W-1:0] channel k at [k*W +: W]
//   in_last    in  [7:0]    per-channel end-of-packet
//   in_ready   out [7:0]    per-channel accept, at most one bit high
//   out_valid  out 1        output beat valid
//   out_data   out [W-1:0]  selected data
//   out_sel    out [2:0]    source channel of the current beat
//   out_last   out 1        in_last of the current beat
//   out_ready  in  1        downstream accept
// -----------------------------------------------------------------------------
module rr_mux8
    import rr_mux8_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel,
    output logic              out_last,
    input  logic              out_ready
);

    sel_t            ptr_reg;
    logic            load;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] gnt;
    sel_t            gnt_idx;
    logic            any;
    logic [W-1:0]    ch_data [N_CH];

    // Unpack the flat data bus into per-channel words.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // Output register is empty or being drained this cycle.
    assign load = ~out_valid | out_ready;

`ifdef RR_MUX8_PKT_LOCK_EN
    logic lock_reg;

    // While locked, ptr_reg holds the owning channel; masking the request
    // vector to that channel keeps everyone else out even if it stalls.
    always_comb begin
        req = in_valid;
        if (lock_reg) begin
            req = in_valid & (N_CH'(1) << ptr_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_reg <= 1'b0;
        end else if (load && any) begin
            lock_reg <= ~in_last[gnt_idx];
        end
    end
`else
    assign req = in_valid;
`endif

    // rst_n gates the enable so in_ready stays low while reset is held,
    // whatever the inputs are doing.
    rr_arb8 u_arb (
        .req     (req),
        .ptr     (ptr_reg),
        .en      (load & rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign in_ready = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            ptr_reg   <= sel_t'(N_CH - 1);
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[gnt_idx];
                out_sel   <= gnt_idx;
                out_last  <= in_last[gnt_idx];
                ptr_reg   <= gnt_idx;
            end else begin
                // Nothing to send: drop valid, keep payload and pointer.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux8.sv
// -----------------------------------------------------------------------------
// tb_rr_mux8
// Directed testbench for rr_mux8 (W=8) with hand-computed expectations.
// Honours RR_MUX8_PKT_LOCK_EN for the packet-lock scenario.
// -----------------------------------------------------------------------------
module tb_rr_mux8;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_last;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_sel;
    logic        out_last;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

    rr_mux8 #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer: check the combinational accept, clock it, check the beat.
    task automatic beat(input string tag, input logic [7:0] rdy,
                        input logic [2:0] sel, input logic [7:0] data);
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        tick();
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_sel"}, 32'(out_sel), 32'(sel));
        check({tag, ".out_data"}, 32'(out_data), 32'(data));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_sel  [5];
        logic [7:0] exp_data [5];
        int         n_beats;
        int         c2;
        logic       took2;

        // ---------------- reset with random inputs ----------------
        rst_n     = 1'b0;
        in_valid  = 8'($urandom);
        in_data   = {$urandom, $urandom};
        in_last   = 8'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        tick();
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_sel", 32'(out_sel), 32'd0);
        check("rst.out_data", 32'(out_data), 32'd0);
        check("rst.out_last", 32'(out_last), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);

        rst_n         = 1'b1;
        in_valid      = 8'h01;
        in_data[7:0]  = 8'hA5;
        in_last       = 8'hFF;
        out_ready     = 1'b1;
        beat("rst_release", 8'h01, 3'd0, 8'hA5);
        check("rst_release.out_last", 32'(out_last), 32'd1);

        // ---------------- fairness ----------------
        in_valid = 8'h00;
        do_reset();
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            beat($sformatf("fair%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 8'(8'h10 + (k % 8)));
        end

        // ---------------- backpressure (holding ch0 beat, ptr=0) ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
            tick();
            check($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d.out_sel", k), 32'(out_sel), 32'd0);
            check($sformatf("bp%0d.out_data", k), 32'(out_data), 32'h10);
        end
        out_ready = 1'b1;
        beat("bp_release", 8'h02, 3'd1, 8'h11);

        // ---------------- sparse wrap ----------------
        in_valid = 8'h80;
        beat("wrap_g7", 8'h80, 3'd7, 8'h17);
        in_valid = 8'h81;
        beat("wrap_a", 8'h01, 3'd0, 8'h10);
        beat("wrap_b", 8'h80, 3'd7, 8'h17);
        beat("wrap_c", 8'h01, 3'd0, 8'h10);
        beat("wrap_d", 8'h80, 3'd7, 8'h17);
        in_valid = 8'h08;
        for (int k = 0; k < 3; k++) begin
            beat($sformatf("single%0d", k), 8'h08, 3'd3, 8'h13);
        end

        // ---------------- idle, pointer held at 3 ----------------
        in_valid = 8'h00;
        #1;
        check("idle.in_ready", 32'(in_ready), 32'd0);
        tick();
        check("idle.out_valid", 32'(out_valid), 32'd0);
        check("idle.out_sel", 32'(out_sel), 32'd3);
        check("idle.out_data", 32'(out_data), 32'h13);
        in_valid = 8'hFF;
        beat("after_idle_a", 8'h10, 3'd4, 8'h14);
        beat("after_idle_b", 8'h20, 3'd5, 8'h15);

        // ---------------- packet: ch2 three beats vs ch5 ----------------
        in_valid = 8'h00;
        do_reset();
`ifdef RR_MUX8_PKT_LOCK_EN
        n_beats = 4;
        exp_sel  = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd0};
        exp_data = '{8'h30, 8'h31, 8'h32, 8'h55, 8'h00};
`else
        n_beats = 5;
        exp_sel  = '{3'd2, 3'd5, 3'd2, 3'd5, 3'd2};
        exp_data = '{8'h30, 8'h55, 8'h31, 8'h55, 8'h32};
`endif
        in_data[5*8 +: 8] = 8'h55;
        c2 = 0;
        for (int b = 0; b < n_beats; b++) begin
            in_valid          = (c2 < 3) ? 8'h24 : 8'h20;
            in_last           = (c2 == 2) ? 8'h24 : 8'h20;
            in_data[2*8 +: 8] = 8'(8'h30 + c2);
            #1;
            took2 = in_valid[2] & in_ready[2];
            tick();
            check($sformatf("pkt%0d.out_sel", b), 32'(out_sel), 32'(exp_sel[b]));
            check($sformatf("pkt%0d.out_data", b), 32'(out_data), 32'(exp_data[b]));
            if (took2) c2++;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
